// File: rtl/route_pkg.sv
// Shared types and default geometry for the route buffer sequencer.
package route_pkg;

    localparam int unsigned ROUTE_NUM_LANES = 10;
    localparam int unsigned ROUTE_ADDR_W    = 4;
    localparam int unsigned ROUTE_LANE_W    = 16;
    localparam int unsigned ROUTE_LUT_LAT   = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_L1,
        LOAD_L1,
        LUT_OUT,
        LUT_WAIT,
        LUT_WB,
        DRAIN,
        DONE
    } route_state_t;

endpackage

// File: rtl/route_lane_cnt.sv
// Lane index and LUT latency counters; both saturate at their terminal value.
module route_lane_cnt
    import route_pkg::*;
#(
    parameter int unsigned NUM_LANES = ROUTE_NUM_LANES,
    parameter int unsigned ADDR_W    = ROUTE_ADDR_W,
    parameter int unsigned LUT_LAT   = ROUTE_LUT_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_lane_clr,
    input  logic              i_lane_inc,
    input  logic              i_wait_clr,
    input  logic              i_wait_inc,
    output logic [ADDR_W-1:0] o_lane_nxt_c,
    output logic              o_lane_last_c,
    output logic              o_wait_last_c
);

    localparam int unsigned WAIT_W = (LUT_LAT > 1) ? $clog2(LUT_LAT) : 1;

    logic [ADDR_W-1:0] r_lane;
    logic [ADDR_W-1:0] w_lane_nxt;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_nxt;

    // Terminal compares rather than modulo so neither counter can wrap.
    assign o_lane_last_c = (r_lane == ADDR_W'(NUM_LANES - 1));
    assign o_wait_last_c = (r_wait == WAIT_W'(LUT_LAT - 1));
    assign o_lane_nxt_c  = w_lane_nxt;

    always_comb begin
        w_lane_nxt = r_lane;
        w_wait_nxt = r_wait;
        if (i_lane_clr) begin
            w_lane_nxt = '0;
        end else if (i_lane_inc && !o_lane_last_c) begin
            w_lane_nxt = r_lane + ADDR_W'(1);
        end
        if (i_wait_clr) begin
            w_wait_nxt = '0;
        end else if (i_wait_inc && !o_wait_last_c) begin
            w_wait_nxt = r_wait + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lane <= '0;
            r_wait <= '0;
        end else begin
            r_lane <= w_lane_nxt;
            r_wait <= w_wait_nxt;
        end
    end

endmodule

// File: rtl/route_seq_ctrl.sv
// Route buffer sequencer: L1 capture, per-lane LUT read/wait/write-back, hand-off to stage 2.
// Optional build macro ROUTE_SEQ_BYPASS_EN lets lut_bypass skip the LUT loop.
module route_seq_ctrl
    import route_pkg::*;
#(
    parameter int unsigned NUM_LANES = ROUTE_NUM_LANES,
    parameter int unsigned ADDR_W    = ROUTE_ADDR_W,
    parameter int unsigned LUT_LAT   = ROUTE_LUT_LAT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              l1_valid,
    input  logic              lut_bypass,
    input  logic              stage2_ready,
    output logic              DataSel,
    output logic              OutSel,
    output logic              RegIn,
    output logic              RegOut,
    output logic [ADDR_W-1:0] Addr,
    output logic              stage2_valid,
    output logic              busy,
    output logic              done
);

    route_state_t      r_state;
    route_state_t      w_state_nxt;
    logic              w_lane_clr;
    logic              w_lane_inc;
    logic              w_wait_clr;
    logic              w_wait_inc;
    logic [ADDR_W-1:0] w_lane_nxt;
    logic              w_lane_last;
    logic              w_wait_last;
    logic              w_bypass;

    logic              r_data_sel;
    logic              r_out_sel;
    logic              r_reg_in;
    logic              r_reg_out;
    logic [ADDR_W-1:0] r_addr;
    logic              r_stage2_valid;
    logic              r_busy;
    logic              r_done;

`ifdef ROUTE_SEQ_BYPASS_EN
    assign w_bypass = lut_bypass;
`else
    logic w_unused_bypass;
    assign w_unused_bypass = lut_bypass;
    assign w_bypass        = 1'b0;
`endif

    route_lane_cnt #(
        .NUM_LANES (NUM_LANES),
        .ADDR_W    (ADDR_W),
        .LUT_LAT   (LUT_LAT)
    ) u_lane_cnt (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_lane_clr    (w_lane_clr),
        .i_lane_inc    (w_lane_inc),
        .i_wait_clr    (w_wait_clr),
        .i_wait_inc    (w_wait_inc),
        .o_lane_nxt_c  (w_lane_nxt),
        .o_lane_last_c (w_lane_last),
        .o_wait_last_c (w_wait_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_lane_clr  = 1'b0;
        w_lane_inc  = 1'b0;
        w_wait_clr  = 1'b0;
        w_wait_inc  = 1'b0;
        case (r_state)
            IDLE:     if (start) w_state_nxt = WAIT_L1;
            WAIT_L1:  if (l1_valid) w_state_nxt = LOAD_L1;
            LOAD_L1: begin
                w_lane_clr  = 1'b1;
                w_state_nxt = w_bypass ? DRAIN : LUT_OUT;
            end
            LUT_OUT: begin
                w_wait_clr  = 1'b1;
                w_state_nxt = LUT_WAIT;
            end
            LUT_WAIT: begin
                if (w_wait_last) w_state_nxt = LUT_WB;
                else             w_wait_inc  = 1'b1;
            end
            LUT_WB: begin
                if (w_lane_last) begin
                    w_state_nxt = DRAIN;
                end else begin
                    w_lane_inc  = 1'b1;
                    w_state_nxt = LUT_OUT;
                end
            end
            DRAIN:    if (stage2_ready) w_state_nxt = DONE;
            DONE:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Outputs are the Moore decode of the next state, registered so they line up with r_state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_sel     <= 1'b0;
            r_out_sel      <= 1'b0;
            r_reg_in       <= 1'b0;
            r_reg_out      <= 1'b0;
            r_addr         <= '0;
            r_stage2_valid <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_data_sel     <= (w_state_nxt == LUT_WB);
            r_out_sel      <= (w_state_nxt == DRAIN);
            r_reg_in       <= (w_state_nxt == LOAD_L1) || (w_state_nxt == LUT_WB);
            r_reg_out      <= (w_state_nxt == LUT_OUT);
            r_addr         <= (w_state_nxt inside {LUT_OUT, LUT_WAIT, LUT_WB}) ? w_lane_nxt : '0;
            r_stage2_valid <= (w_state_nxt == DRAIN);
            r_busy         <= (w_state_nxt != IDLE);
            r_done         <= (w_state_nxt == DONE);
        end
    end

    assign DataSel      = r_data_sel;
    assign OutSel       = r_out_sel;
    assign RegIn        = r_reg_in;
    assign RegOut       = r_reg_out;
    assign Addr         = r_addr;
    assign stage2_valid = r_stage2_valid;
    assign busy         = r_busy;
    assign done         = r_done;

endmodule

// File: tb/tb_route_seq_ctrl.sv
// Directed bench for route_seq_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_route_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       l1_valid;
    logic       lut_bypass;
    logic       stage2_ready;
    logic       DataSel;
    logic       OutSel;
    logic       RegIn;
    logic       RegOut;
    logic [3:0] Addr;
    logic       stage2_valid;
    logic       busy;
    logic       done;
    logic [10:0] act;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        l1v;
        logic        byp;
        logic        rdy;
        logic [10:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    route_seq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .l1_valid     (l1_valid),
        .lut_bypass   (lut_bypass),
        .stage2_ready (stage2_ready),
        .DataSel      (DataSel),
        .OutSel       (OutSel),
        .RegIn        (RegIn),
        .RegOut       (RegOut),
        .Addr         (Addr),
        .stage2_valid (stage2_valid),
        .busy         (busy),
        .done         (done)
    );

    assign act = {DataSel, OutSel, RegIn, RegOut, Addr, stage2_valid, busy, done};

    function automatic logic [10:0] mk(input logic ds, input logic os, input logic rin,
                                       input logic rout, input logic [3:0] a,
                                       input logic s2v, input logic bsy, input logic dn);
        return {ds, os, rin, rout, a, s2v, bsy, dn};
    endfunction

    // Expected outputs in cycle c of an uninterrupted pass whose start was seen in cycle 0.
    function automatic logic [10:0] exp_pass(input int c);
        int lane;
        int ph;
        logic [3:0] a;
        if (c == 1) return mk(0, 0, 0, 0, 4'd0, 0, 1, 0);
        if (c == 2) return mk(0, 0, 1, 0, 4'd0, 0, 1, 0);
        if (c >= 3 && c <= 42) begin
            lane = (c - 3) / 4;
            ph   = (c - 3) % 4;
            a    = 4'(lane);
            if (ph == 0) return mk(0, 0, 0, 1, a, 0, 1, 0);
            if (ph == 3) return mk(1, 0, 1, 0, a, 0, 1, 0);
            return mk(0, 0, 0, 0, a, 0, 1, 0);
        end
        if (c == 43) return mk(0, 1, 0, 0, 4'd0, 1, 1, 0);
        if (c == 44) return mk(0, 0, 0, 0, 4'd0, 0, 1, 1);
        return 11'd0;
    endfunction

    task automatic apply(input logic rn, input logic st, input logic lv, input logic bp,
                         input logic rd, input logic [10:0] exp, input string name,
                         input int c);
        rst_n        = rn;
        start        = st;
        l1_valid     = lv;
        lut_bypass   = bp;
        stage2_ready = rd;
        @(posedge clk);
        #1;
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s c%0d: got %b want %b (ds os rin rout addr s2v busy done)",
                     name, c, act, exp);
        end
    endtask

    task automatic push(input logic rn, input logic st, input logic lv, input logic bp,
                        input logic rd, input logic [10:0] exp, input string name);
        vec_t v;
        v.rst_n = rn; v.start = st; v.l1v = lv; v.byp = bp; v.rdy = rd;
        v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    initial begin
        int n_rout;
        int n_rin;
        logic [10:0] e;
        rst_n = 1'b0; start = 1'b0; l1_valid = 1'b0; lut_bypass = 1'b0; stage2_ready = 1'b0;

        // Reset, idle without start, then one full pass with everything ready.
        push(0, 0, 0, 0, 0, 11'd0, "reset");
        push(0, 1, 1, 0, 1, 11'd0, "reset");
        for (int i = 0; i < 3; i++) push(1, 0, 0, 0, 0, 11'd0, "idle");
        for (int c = 1; c <= 46; c++) push(1, (c == 1), 1, 0, 1, exp_pass(c), "pass");

        n_rout = 0;
        n_rin  = 0;
        foreach (tbl[i]) begin
            apply(tbl[i].rst_n, tbl[i].start, tbl[i].l1v, tbl[i].byp, tbl[i].rdy,
                  tbl[i].exp, tbl[i].name, i);
            if (tbl[i].name == "pass") begin
                n_rout += int'(RegOut);
                n_rin  += int'(RegIn);
            end
        end
        n_vec++;
        if (n_rout != 10) begin
            n_bad++;
            $display("FAIL regout_count: got %0d want 10", n_rout);
        end
        n_vec++;
        if (n_rin != 11) begin
            n_bad++;
            $display("FAIL regin_count: got %0d want 11", n_rin);
        end

        // Backpressure in DRAIN; early ready pulses outside DRAIN must not matter.
        for (int c = 1; c <= 50; c++) begin
            if (c <= 42)      e = exp_pass(c);
            else if (c <= 48) e = mk(0, 1, 0, 0, 4'd0, 1, 1, 0);
            else if (c == 49) e = mk(0, 0, 0, 0, 4'd0, 0, 1, 1);
            else              e = 11'd0;
            apply(1, (c == 1), 1, 0, (c >= 49) || (c >= 10 && c <= 20), e, "backpressure", c);
        end

        // L1 stall, l1_valid drop after load, start while busy, then reset mid LUT_WAIT.
        for (int c = 1; c <= 40; c++) begin
            if (c <= 8)       e = mk(0, 0, 0, 0, 4'd0, 0, 1, 0);
            else if (c <= 35) e = exp_pass(c - 7);
            else              e = 11'd0;
            apply(!(c == 36 || c == 37), (c == 1) || (c == 27), (c == 9 || c == 10), 0, 0,
                  e, "stall_reset", c);
        end

`ifdef ROUTE_SEQ_BYPASS_EN
        // Bypass skips the LUT loop entirely.
        for (int c = 1; c <= 5; c++) begin
            if (c <= 2)       e = exp_pass(c);
            else if (c == 3)  e = mk(0, 1, 0, 0, 4'd0, 1, 1, 0);
            else if (c == 4)  e = mk(0, 0, 0, 0, 4'd0, 0, 1, 1);
            else              e = 11'd0;
            apply(1, (c == 1), 1, 1, 1, e, "bypass", c);
        end
`else
        // Without the bypass feature lut_bypass is ignored and the LUT loop runs.
        for (int c = 1; c <= 46; c++) begin
            apply(1, (c == 1), 1, 1, 1, exp_pass(c), "bypass_ignored", c);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
